// File: rtl/led_pattern_pkg.sv
// ---------------------------------------------------------------------------
// led_pattern_pkg
// Shared types and constants for the LED pattern generator.
//   mode_t          : pattern selection (rotate, bounce, count, fill)
//   bounce_state_t  : direction of travel of the bouncing bit
//   PWM_W           : width of the optional brightness PWM counter / duty
//   mode_seed_is_one: whether a mode starts from the value 1 (else from 0)
// ---------------------------------------------------------------------------
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_FILL   = 2'd3
    } mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } bounce_state_t;

    localparam int PWM_W = 8;

    // Rotate and bounce start with a single lit LSB; count and fill start empty.
    function automatic logic mode_seed_is_one(mode_t m);
        return (m == MODE_ROTATE) || (m == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// led_tick_gen
// Down-counting prescaler that produces the step strobe for the pattern
// generator. The strobe is asserted whenever the counter sits at zero while
// enabled, and on that same cycle the counter reloads from div, so a div of
// N gives one strobe every N+1 enabled cycles (div=0 strobes every cycle).
// div is only sampled at reload, so changing it never shortens or stretches
// the period already in progress. en low freezes the counter.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (counter cleared to zero)
//   en    : run enable
//   div   : step period minus one, in clk cycles
//   tick  : step strobe, registered by the consumer
// ---------------------------------------------------------------------------
module led_tick_gen #(
    parameter int NDIV = 25
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NDIV-1:0] div,
    output logic            tick
);

    localparam logic [NDIV-1:0] COUNT_ONE = NDIV'(1);

    logic [NDIV-1:0] count_q;

    // Reset leaves the counter at zero so the first enabled cycle steps.
    assign tick = en && (count_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en) begin
            if (tick) begin
                count_q <= div;
            end else begin
                count_q <= count_q - COUNT_ONE;
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Drives a bank of NLED LEDs with one of four animated patterns, advancing
// one step per prescaler strobe. Also exposes an 8-bit step counter and a
// single-cycle step pulse aligned with the cycle in which the pattern
// changes. The pmod output is the pattern registered once more, optionally
// inverted for active-low LEDs.
//
// Optional feature (macro LED_PATTERN_PWM_EN): adds an 8-bit duty input and
// a free-running PWM counter that gates active bits (before inversion) so
// each lit LED is on only while the PWM counter is below duty.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : run enable, low freezes prescaler and pattern
//   mode  : pattern select (mode_t)
//   div   : step period minus one, in clk cycles
//   duty  : brightness (only with LED_PATTERN_PWM_EN)
//   pmod  : registered, optionally inverted pattern
//   led   : registered step counter, modulo 256
//   tick  : registered single-cycle step pulse
// ---------------------------------------------------------------------------
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NLED       = 32,
    parameter int NDIV       = 25,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  mode_t            mode,
    input  logic [NDIV-1:0]  div,
`ifdef LED_PATTERN_PWM_EN
    input  logic [PWM_W-1:0] duty,
`endif
    output logic [NLED-1:0]  pmod,
    output logic [7:0]       led,
    output logic             tick
);

    localparam logic [NLED-1:0] PAT_ONE  = NLED'(1);
    localparam logic [NLED-1:0] INV_MASK = {NLED{ACTIVE_LOW != 0}};

    logic            step;
    logic [NLED-1:0] pattern_q, pattern_d;
    mode_t           mode_q, mode_d;
    bounce_state_t   state_q, state_d;
    logic [7:0]      led_q;
    logic            tick_q;
    logic [NLED-1:0] pmod_q;
    logic [NLED-1:0] gated;

    led_tick_gen #(
        .NDIV (NDIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .div   (div),
        .tick  (step)
    );

    // Next pattern, registered mode and bounce direction. A mode change takes
    // priority over stepping: the new mode's seed is loaded instead of any
    // step of the old mode, and the bounce FSM restarts travelling upward.
    // Bounce turns around on the step that lands on an end bit, so each end
    // bit is displayed for exactly one step.
    always_comb begin
        pattern_d = pattern_q;
        mode_d    = mode_q;
        state_d   = state_q;
        if (step) begin
            if (mode != mode_q) begin
                mode_d    = mode;
                state_d   = UP;
                pattern_d = mode_seed_is_one(mode) ? PAT_ONE : '0;
            end else begin
                case (mode_q)
                    MODE_ROTATE: begin
                        pattern_d = {pattern_q[0], pattern_q[NLED-1:1]};
                    end
                    MODE_BOUNCE: begin
                        if (state_q == UP) begin
                            pattern_d = {pattern_q[NLED-2:0], 1'b0};
                            if (pattern_q[NLED-2]) begin
                                state_d = DOWN;
                            end
                        end else begin
                            pattern_d = {1'b0, pattern_q[NLED-1:1]};
                            if (pattern_q[1]) begin
                                state_d = UP;
                            end
                        end
                    end
                    MODE_COUNT: begin
                        pattern_d = pattern_q + PAT_ONE;
                    end
                    MODE_FILL: begin
                        pattern_d = (&pattern_q) ? '0 : {pattern_q[NLED-2:0], 1'b1};
                    end
                    default: begin
                        pattern_d = pattern_q;
                    end
                endcase
            end
        end
    end

    // Pattern, mode, FSM, step counter and step pulse all update on the same
    // edge so tick is high exactly in the cycle showing the new pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= PAT_ONE;
            mode_q    <= MODE_ROTATE;
            state_q   <= UP;
            led_q     <= 8'd0;
            tick_q    <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            mode_q    <= mode_d;
            state_q   <= state_d;
            tick_q    <= step;
            if (step) begin
                led_q <= led_q + 8'd1;
            end
        end
    end

`ifdef LED_PATTERN_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    // Free-running PWM counter; duty=0 never lights, duty=255 lights 255/256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    assign gated = pattern_q & {NLED{pwm_cnt < duty}};
`else
    assign gated = pattern_q;
`endif

    // Output stage: gating is applied first, then polarity inversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmod_q <= PAT_ONE ^ INV_MASK;
        end else begin
            pmod_q <= gated ^ INV_MASK;
        end
    end

    assign pmod = pmod_q;
    assign led  = led_q;
    assign tick = tick_q;

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter NLED, default 32, meaning pattern width in bits (range 4..64).
REQ-002 SHALL have parameter NDIV, default 25, meaning prescaler counter width in bits.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, meaning that when 1 the pattern is inverted at the pmod output.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1, run enable; low freezes the prescaler and the pattern.
REQ-007 SHALL have port mode, input, 2, pattern select, of type mode_t.
REQ-008 SHALL have port div, input, NDIV, step period minus 1, in clk cycles.
REQ-009 SHALL have port duty, input, 8, brightness; present only with LED_PATTERN_PWM_EN.
REQ-010 SHALL have port pmod, output, NLED, registered pattern output.
REQ-011 SHALL have port led, output, 8, registered step counter.
REQ-012 SHALL have port tick, output, 1, single-cycle pulse on each pattern step.

Function
REQ-013 Prescaler SHALL count down when en=1, assert tick when count==0, and reload from div on that same cycle; div=0 SHALL tick every enabled cycle.
REQ-014 div changes SHALL take effect only at the next reload, never mid-period.
REQ-015 MODE_ROTATE (0): pattern SHALL have seed with only bit0 active and rotate right by 1 per tick, with bit0 wrapping to bit NLED-1.
REQ-016 MODE_BOUNCE (1): a single active bit SHALL move via FSM states UP (toward MSB) and DOWN (toward LSB).
REQ-017 In MODE_BOUNCE, the FSM SHALL switch UP->DOWN on the tick that puts the active bit at NLED-1, and DOWN->UP on the tick that puts it at bit0; the end bit SHALL be shown for exactly one step.
REQ-018 MODE_COUNT (2): pattern SHALL be a binary counter incrementing per tick and wrapping from all-ones to 0.
REQ-019 MODE_FILL (3): pattern SHALL be a thermometer that sets one more bit from the LSB per tick; after the all-ones step, the next tick SHALL give 0.
REQ-020 When mode differs from the registered mode, on the next tick the pattern SHALL load that mode's seed and the FSM SHALL go to UP; no step of the old mode is taken.
REQ-021 Seeds SHALL be: ROTATE=1, BOUNCE=1, COUNT=0, FILL=0.
REQ-022 led SHALL increment modulo 256 on every tick, regardless of mode.
REQ-023 pmod SHALL equal the pattern XOR {NLED{ACTIVE_LOW}}, registered one cycle after the pattern update.
REQ-024 tick SHALL be registered and align with the cycle in which the pattern changes.
REQ-025 en low during a period SHALL hold the count; resuming SHALL continue from the held value.

Reset
REQ-026 On rst_n low, asynchronously: prescaler=0, pattern=ROTATE seed, registered mode=ROTATE, FSM=UP, led=0, tick=0.
REQ-027 On rst_n low, pmod SHALL be ACTIVE_LOW ? ~1 : 1 (for 32 bits with ACTIVE_LOW: 32'hFFFF_FFFE).
REQ-028 On the first enabled cycle after reset release, a tick SHALL occur (prescaler=0).

Configuration
REQ-029 With LED_PATTERN_PWM_EN defined: an 8-bit free-running PWM counter SHALL gate pmod active bits so each is active only while pwm_cnt < duty.
REQ-030 With LED_PATTERN_PWM_EN, duty=0 SHALL drive all bits inactive and duty=255 SHALL give 255/256 active time.
REQ-031 With LED_PATTERN_PWM_EN, the gating SHALL be applied before inversion.
REQ-032 Without LED_PATTERN_PWM_EN: no duty port, no PWM logic, and pmod as in REQ-023.

Structure
REQ-033 Package led_pattern_pkg SHALL hold typedef mode_t (MODE_ROTATE, MODE_BOUNCE, MODE_COUNT, MODE_FILL), typedef bounce_state_t (UP, DOWN), and localparam PWM_W=8.
REQ-034 The prescaler SHALL be a sub-module led_tick_gen (ports: clk, rst_n, en, div, tick).

Verification
REQ-035 NLED=8, div=3, ROTATE, en=1 -> tick every 4 cycles; pattern 01,80,40,20... ; pmod = ~pattern.
REQ-036 NLED=8, div=0, BOUNCE -> pattern 01,02,04,...,80,40,...,01,02; 80 and 01 each held one step.
REQ-037 NLED=8, COUNT, 260 ticks -> pattern 04 after wrap; led=04.
REQ-038 FILL running at pattern 07, switch mode to ROTATE mid-period -> next tick pattern=01, no 0F step.
REQ-039 div=9, en=0 after 5 cycles for 20 cycles, then en=1 -> next tick exactly 5 enabled cycles later; rst_n asserted mid-period -> outputs reset immediately, without waiting for clk.
REQ-040 With LED_PATTERN_PWM_EN, duty=64, ACTIVE_LOW=0 -> active bit high 64 of every 256 cycles; duty=0 -> pmod=0.
